// File: rtl/halton_pkg.sv
// Shared definitions for the N-dimensional Halton generator.
// Holds the prime base table, the FSM state type and the constant
// functions that size the digit odometers and build the weight and
// carry-correction tables used by each dimension unit.
package halton_pkg;

  localparam int unsigned MAX_DIM = 8;
  localparam int unsigned PRIMES [MAX_DIM] = '{2, 3, 5, 7, 11, 13, 17, 19};

  typedef enum logic {
    ST_IDLE,
    ST_LOAD
  } state_e;

  // Smallest n such that base^n covers every index value of k_width bits.
  function automatic int unsigned ndig(input int unsigned base,
                                       input int unsigned k_width);
    logic [127:0] p;
    logic [127:0] lim;
    int unsigned  n;
    p   = 128'd1;
    lim = 128'd1 << k_width;
    n   = 0;
    while (p < lim) begin
      p = p * 128'(base);
      n++;
    end
    return n;
  endfunction

  // Longest digit extraction among the first dim active bases.
  function automatic int unsigned ndig_max(input int unsigned dim,
                                           input int unsigned k_width);
    int unsigned m;
    m = 0;
    for (int unsigned d = 0; d < dim; d++) begin
      if (ndig(PRIMES[d], k_width) > m) m = ndig(PRIMES[d], k_width);
    end
    return m;
  endfunction

  // floor(2^width / base^(i+1)); the power saturates once it exceeds
  // 2^width so deep digits simply get a zero weight.
  function automatic logic [63:0] weight(input int unsigned base,
                                         input int unsigned i,
                                         input int unsigned width);
    logic [127:0] num;
    logic [127:0] p;
    num = 128'd1 << width;
    p   = 128'(base);
    for (int unsigned e = 0; e < i; e++) begin
      if (p <= num) p = p * 128'(base);
    end
    return 64'(num / p);
  endfunction

  // Accumulator step when digit j increments and every lower digit
  // rolls over from base-1 to 0, taken modulo 2^width.
  function automatic logic [63:0] corr(input int unsigned base,
                                       input int unsigned j,
                                       input int unsigned width);
    logic [127:0] s;
    logic [127:0] c;
    logic [127:0] mask;
    s = '0;
    for (int unsigned i = 0; i < j; i++) s = s + 128'(weight(base, i, width));
    c    = 128'(weight(base, j, width)) - 128'(base - 1) * s;
    mask = (128'd1 << width) - 128'd1;
    return 64'(c & mask);
  endfunction

endpackage

// File: rtl/halton_dim_unit.sv
// One Halton dimension: a base-BASE digit odometer plus the running
// fixed-point radical inverse (acc) of the digits it holds.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   clear_i      start a reseed: zero digits/acc, latch seed_i as remainder
//   load_i       one extraction step for digit position load_idx_i
//   load_idx_i   digit position being extracted this cycle
//   inc_i        advance the odometer by one
//   wrap_i       index wrapped: zero digits and acc (beats inc_i)
//   seed_i       reseed start index
//   acc_o        current radical inverse, WIDTH fraction bits
module halton_dim_unit
  import halton_pkg::*;
#(
  parameter int unsigned BASE    = 2,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned K_WIDTH = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [CNT_W-1:0]   load_idx_i,
  input  logic               inc_i,
  input  logic               wrap_i,
  input  logic [K_WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0]   acc_o
);

  localparam int unsigned NDIG = ndig(BASE, K_WIDTH);
  localparam int unsigned DW   = $clog2(BASE);
  localparam logic [K_WIDTH-1:0] BASE_K = K_WIDTH'(BASE);
  localparam logic [DW-1:0]      DMAX   = DW'(BASE - 1);

  logic [NDIG-1:0][DW-1:0] dig_q, dig_d;
  logic [WIDTH-1:0]        acc_q, acc_d;
  logic [K_WIDTH-1:0]      r_q, r_d;

  logic [WIDTH-1:0] weight_tab [NDIG];
  logic [WIDTH-1:0] corr_tab   [NDIG];

  for (genvar g = 0; g < NDIG; g++) begin : g_tab
    assign weight_tab[g] = WIDTH'(weight(BASE, g, WIDTH));
    assign corr_tab[g]   = WIDTH'(corr(BASE, g, WIDTH));
  end

  logic [DW-1:0]    ext_dig;
  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] c_sel;
  logic             found;

  // Next state: reseed clear, one digit extraction per LOAD step, wrap
  // clear, or odometer increment where the lowest non-max digit picks
  // the precomputed accumulator correction.
  always_comb begin
    dig_d   = dig_q;
    acc_d   = acc_q;
    r_d     = r_q;
    w_sel   = '0;
    c_sel   = '0;
    found   = 1'b0;
    ext_dig = DW'(r_q % BASE_K);
    if (clear_i) begin
      dig_d = '0;
      acc_d = '0;
      r_d   = seed_i;
    end else if (load_i) begin
      r_d = r_q / BASE_K;
      for (int i = 0; i < NDIG; i++) begin
        if (load_idx_i == CNT_W'(i)) begin
          dig_d[i] = ext_dig;
          w_sel    = weight_tab[i];
        end
      end
      acc_d = acc_q + WIDTH'(ext_dig) * w_sel;
    end else if (wrap_i) begin
      dig_d = '0;
      acc_d = '0;
    end else if (inc_i) begin
      for (int i = 0; i < NDIG; i++) begin
        if (!found) begin
          if (dig_q[i] == DMAX) begin
            dig_d[i] = '0;
          end else begin
            dig_d[i] = dig_q[i] + DW'(1);
            c_sel    = corr_tab[i];
            found    = 1'b1;
          end
        end
      end
      acc_d = found ? acc_q + c_sel : '0;
    end
  end

  // Digit, accumulator and remainder registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q <= '0;
      acc_q <= '0;
      r_q   <= '0;
    end else begin
      dig_q <= dig_d;
      acc_q <= acc_d;
      r_q   <= r_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/halton_nd_gen.sv
// N-dimensional Halton sequence generator, one DIM-tuple per pop.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   pop_enable     advance the index and present the next point
//   reseed_enable  restart from index seed (multi-cycle digit load)
//   seed           start index for reseed
//   halton_out     packed points, dimension d at [d*WIDTH +: WIDTH]
//   valid          one-cycle pulse per accepted pop
//   busy           high while a reseed digit load is running
//   wrapped        pulses with valid when the index rolled over to 0
module halton_nd_gen
  import halton_pkg::*;
#(
  parameter int unsigned DIM     = 2,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned K_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pop_enable,
  input  logic                 reseed_enable,
  input  logic [K_WIDTH-1:0]   seed,
  output logic [DIM*WIDTH-1:0] halton_out,
  output logic                 valid,
  output logic                 busy,
  output logic                 wrapped
);

  localparam int unsigned NDIG_MAX = ndig_max(DIM, K_WIDTH);
  localparam int unsigned CNT_W    = (NDIG_MAX > 1) ? $clog2(NDIG_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG_MAX - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [K_WIDTH-1:0] k_q, k_d;
  logic [K_WIDTH-1:0] seed_q, seed_d;
  logic               valid_q, valid_d;
  logic               wrapped_q, wrapped_d;
  logic               accept_pop, wrap_pop, load_step;

  // Control: reseed always wins and restarts the load; pops only land in
  // IDLE; the last LOAD step commits the seed as the live index.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    seed_d     = seed_q;
    valid_d    = 1'b0;
    wrapped_d  = 1'b0;
    accept_pop = 1'b0;
    wrap_pop   = 1'b0;
    load_step  = 1'b0;
    if (reseed_enable) begin
      state_d = ST_LOAD;
      cnt_d   = '0;
      seed_d  = seed;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop_enable) begin
            accept_pop = 1'b1;
            valid_d    = 1'b1;
            k_d        = k_q + K_WIDTH'(1);
            if (k_q == '1) begin
              wrap_pop  = 1'b1;
              wrapped_d = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          load_step = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            k_d     = seed_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      seed_q    <= '0;
      valid_q   <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      seed_q    <= seed_d;
      valid_q   <= valid_d;
      wrapped_q <= wrapped_d;
    end
  end

  for (genvar d = 0; d < DIM; d++) begin : g_dim
    halton_dim_unit #(
      .BASE    (PRIMES[d]),
      .WIDTH   (WIDTH),
      .K_WIDTH (K_WIDTH),
      .CNT_W   (CNT_W)
    ) u_dim (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (reseed_enable),
      .load_i     (load_step),
      .load_idx_i (cnt_q),
      .inc_i      (accept_pop),
      .wrap_i     (wrap_pop),
      .seed_i     (seed),
      .acc_o      (halton_out[d*WIDTH +: WIDTH])
    );
  end

  assign valid   = valid_q;
  assign wrapped = wrapped_q;
  assign busy    = (state_q == ST_LOAD);

endmodule

// File: tb/tb_halton_nd_gen.sv
// Scoreboard bench for halton_nd_gen: a default 2-D/32-bit instance and a
// K_WIDTH=4 instance for index wrap. Pops push hand-computed points into a
// per-instance queue; negedge monitors pop and compare on every valid.
module tb_halton_nd_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        pop_enable, reseed_enable;
  logic [31:0] seed;
  logic [63:0] halton_out;
  logic        valid, busy, wrapped;

  logic        pop4, reseed4;
  logic [3:0]  seed4;
  logic [63:0] halton4;
  logic        valid4, busy4, wrapped4;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [63:0] out;
    logic        wrp;
  } exp_t;

  exp_t q2[$];
  exp_t q4[$];

  halton_nd_gen #(.DIM(2), .WIDTH(32), .K_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .pop_enable    (pop_enable),
    .reseed_enable (reseed_enable),
    .seed          (seed),
    .halton_out    (halton_out),
    .valid         (valid),
    .busy          (busy),
    .wrapped       (wrapped)
  );

  halton_nd_gen #(.DIM(2), .WIDTH(32), .K_WIDTH(4)) dut4 (
    .clk           (clk),
    .rst           (rst),
    .pop_enable    (pop4),
    .reseed_enable (reseed4),
    .seed          (seed4),
    .halton_out    (halton4),
    .valid         (valid4),
    .busy          (busy4),
    .wrapped       (wrapped4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%h, want 0x%h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs to either instance, then release them.
  task automatic applyStimulus(input bit toSmall, input logic p, input logic r,
                               input logic [31:0] s);
    if (toSmall) begin
      pop4 = p; reseed4 = r; seed4 = s[3:0];
    end else begin
      pop_enable = p; reseed_enable = r; seed = s;
    end
    @(posedge clk); #1;
    pop_enable = 1'b0; reseed_enable = 1'b0;
    pop4 = 1'b0; reseed4 = 1'b0;
  endtask

  task automatic popExpect(input bit toSmall, input logic [31:0] e0,
                           input logic [31:0] e1, input logic w);
    exp_t e;
    e.out = {e1, e0};
    e.wrp = w;
    if (toSmall) q4.push_back(e);
    else q2.push_back(e);
    applyStimulus(toSmall, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic waitIdle(input bit toSmall, input int expCycles, input string name);
    int n;
    n = 0;
    while (((toSmall ? busy4 : busy) === 1'b1) && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    checkOutput(name, 64'(n), 64'(expCycles));
  endtask

  // Monitor for the default instance.
  always @(negedge clk) begin
    exp_t e;
    if (valid === 1'b1) begin
      if (q2.size() == 0) begin
        checkOutput("unexpected_valid", 64'(valid), 64'd0);
      end else begin
        e = q2.pop_front();
        checkOutput("point", halton_out, e.out);
        checkOutput("wrapped", 64'(wrapped), 64'(e.wrp));
      end
    end else if (wrapped === 1'b1) begin
      checkOutput("wrapped_without_valid", 64'(wrapped), 64'd0);
    end
  end

  // Monitor for the K_WIDTH=4 instance.
  always @(negedge clk) begin
    exp_t e;
    if (valid4 === 1'b1) begin
      if (q4.size() == 0) begin
        checkOutput("k4_unexpected_valid", 64'(valid4), 64'd0);
      end else begin
        e = q4.pop_front();
        checkOutput("k4_point", halton4, e.out);
        checkOutput("k4_wrapped", 64'(wrapped4), 64'(e.wrp));
      end
    end else if (wrapped4 === 1'b1) begin
      checkOutput("k4_wrapped_without_valid", 64'(wrapped4), 64'd0);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pop_enable = 1'b0; reseed_enable = 1'b0; seed = '0;
    pop4 = 1'b0; reseed4 = 1'b0; seed4 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_out", halton_out, 64'd0);
    checkOutput("rst_valid", 64'(valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_wrapped", 64'(wrapped), 64'd0);
    checkOutput("rst_k4_out", halton4, 64'd0);

    $display("[TB] single pops");
    popExpect(1'b0, 32'd2147483648, 32'd1431655765, 1'b0);
    idle(1);
    popExpect(1'b0, 32'd1073741824, 32'd2863311530, 1'b0);
    idle(1);
    popExpect(1'b0, 32'd3221225472, 32'd477218588, 1'b0);
    idle(1);

    $display("[TB] reseed 5");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd5);
    waitIdle(1'b0, 32, "reseed5_busy_cycles");
    checkOutput("reseed5_out", halton_out, {32'd3340530118, 32'd2684354560});
    popExpect(1'b0, 32'd1610612736, 32'd954437176, 1'b0);
    idle(2);

    $display("[TB] back-to-back pops");
    pulseReset();
    popExpect(1'b0, 32'd2147483648, 32'd1431655765, 1'b0);
    popExpect(1'b0, 32'd1073741824, 32'd2863311530, 1'b0);
    popExpect(1'b0, 32'd3221225472, 32'd477218588, 1'b0);
    popExpect(1'b0, 32'd536870912, 32'd1908874353, 1'b0);
    idle(2);

    $display("[TB] K_WIDTH=4 wrap");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd15);
    waitIdle(1'b1, 4, "k4_busy_cycles");
    popExpect(1'b1, 32'd0, 32'd0, 1'b1);
    popExpect(1'b1, 32'd2147483648, 32'd1431655765, 1'b0);
    idle(2);

    $display("[TB] pop with reseed, pop while busy");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    waitIdle(1'b0, 31, "reseed2_busy_cycles");
    checkOutput("reseed2_out", halton_out, {32'd2863311530, 32'd1073741824});
    popExpect(1'b0, 32'd3221225472, 32'd477218588, 1'b0);
    idle(2);

    $display("[TB] reset during load");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd7);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("midload_busy_before", 64'(busy), 64'd1);
    pulseReset();
    checkOutput("midload_busy_after", 64'(busy), 64'd0);
    checkOutput("midload_out_after", halton_out, 64'd0);
    popExpect(1'b0, 32'd2147483648, 32'd1431655765, 1'b0);
    idle(3);

    checkOutput("q2_drained", 64'(q2.size()), 64'd0);
    checkOutput("q4_drained", 64'(q4.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
